// File: rtl/cache_pkg.sv
// +----------------------------------------------------------------------------+
// | cache_pkg                                                                  |
// | Shared cache geometry constants and the writeback FSM state encoding.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package cache_pkg;

    localparam int LINE_BYTES = 32;
    localparam int OFFSET_W   = $clog2(LINE_BYTES);
    localparam int LINE_W     = LINE_BYTES * 8;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_SEND = 2'd1,
        WB_DONE = 2'd2
    } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/cache_line_writeback_if.sv
// +----------------------------------------------------------------------------+
// | cache_line_writeback_if                                                    |
// | Controller request side and memory beat side of the line writeback engine. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface cache_line_writeback_if
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32
);

    logic                       wb_start;
    logic [LINE_W-1:0]          wb_line;
    logic [ADDR_W-OFFSET_W-1:0] wb_line_addr;
    logic                       busy;
    logic                       wb_done;

    logic                       mem_req;
    logic                       mem_ready;
    logic [ADDR_W-1:0]          mem_addr;
    logic [7:0]                 mem_data;

    // master: the writeback engine; slave: controller plus memory port
    modport master (
        input  wb_start, wb_line, wb_line_addr, mem_ready,
        output busy, wb_done, mem_req, mem_addr, mem_data
    );

    modport slave (
        output wb_start, wb_line, wb_line_addr, mem_ready,
        input  busy, wb_done, mem_req, mem_addr, mem_data
    );

endinterface

`default_nettype wire

// File: rtl/line_byte_mux.sv
// +----------------------------------------------------------------------------+
// | line_byte_mux                                                              |
// | Combinational byte select from a cache line; byte 0 sits in bits [7:0].    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module line_byte_mux
    import cache_pkg::*;
(
    input  wire logic [LINE_W-1:0]   line,
    input  wire logic [OFFSET_W-1:0] offset,
    output logic      [7:0]          data_byte
);

    always_comb begin
        data_byte = line[{offset, 3'b000} +: 8];
    end

endmodule

`default_nettype wire

// File: rtl/cache_line_writeback.sv
// +----------------------------------------------------------------------------+
// | cache_line_writeback                                                       |
// | Streams a captured dirty line to memory one byte per accepted beat.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cache_line_writeback
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  wire logic              clk,
    input  wire logic              reset,
    cache_line_writeback_if.master bus
);

    localparam int c_LADDR_W = ADDR_W - OFFSET_W;

    wb_state_t             r_state;
    wb_state_t             w_state_next;
    logic [OFFSET_W-1:0]   r_byte_cnt;
    logic [LINE_W-1:0]     r_line;
    logic [c_LADDR_W-1:0]  r_line_addr;
    logic                  w_beat;
    logic                  w_last_beat;
    logic [7:0]            w_byte;

    assign w_beat      = (r_state == WB_SEND) && bus.mem_ready;
    assign w_last_beat = w_beat && (r_byte_cnt == OFFSET_W'(LINE_BYTES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WB_IDLE: if (bus.wb_start) w_state_next = WB_SEND;
            WB_SEND: if (w_last_beat)  w_state_next = WB_DONE;
            WB_DONE: w_state_next = WB_IDLE;
            default: w_state_next = WB_IDLE;
        endcase
    end

    // Outputs decode the registered state only, so mem_ready/wb_start never reach them
    always_comb begin
        bus.mem_req = 1'b0;
        bus.busy    = 1'b0;
        bus.wb_done = 1'b0;
        case (r_state)
            WB_SEND: begin
                bus.mem_req = 1'b1;
                bus.busy    = 1'b1;
            end
            WB_DONE: begin
                bus.busy    = 1'b1;
                bus.wb_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Counter wraps to 0 naturally on the last beat of the line
    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_cnt  <= '0;
            r_line      <= '0;
            r_line_addr <= '0;
        end else if ((r_state == WB_IDLE) && bus.wb_start) begin
            r_byte_cnt  <= '0;
            r_line      <= bus.wb_line;
            r_line_addr <= bus.wb_line_addr;
        end else if (w_beat) begin
            r_byte_cnt  <= r_byte_cnt + 1'b1;
        end
    end

    line_byte_mux u_line_byte_mux (
        .line      (r_line),
        .offset    (r_byte_cnt),
        .data_byte (w_byte)
    );

    assign bus.mem_data = w_byte;
    assign bus.mem_addr = {r_line_addr, r_byte_cnt};

endmodule

`default_nettype wire
